// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl
// Command sequencer that sits directly upstream of a WIDTH-bit universal
// shift register. It accepts one command per valid/ready handshake,
// drives the register's sel/pi/si controls for the required number of
// cycles, then pulses done for one cycle.
//
// Optional build macro: USR_SEQ_ABORT_EN
//   When defined, adds the 'abort' input. Asserting abort at an edge while
//   a command is executing returns the sequencer to IDLE without a done
//   pulse. When undefined, commands always run to completion.
//
// Ports:
//   clk        in   1       clock, rising-edge
//   rst        in   1       synchronous active-high reset
//   abort      in   1       (USR_SEQ_ABORT_EN only) cancel the running command
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       sequencer can accept a command (IDLE)
//   cmd_op     in   2       00 LOAD, 01 SHL, 10 SHR, 11 ROT
//   cmd_data   in   WIDTH   LOAD value
//   cmd_cnt    in   CNT_W   number of shift/rotate steps
//   cmd_fill   in   1       SHL/SHR serial fill bit; ROT direction (1 = right)
//   po_fb      in   WIDTH   shift register parallel output (feedback)
//   sel        out  2       00 hold, 01 left, 10 right, 11 load
//   pi         out  WIDTH   parallel input to the shift register
//   si         out  1       serial input to the shift register
//   busy       out  1       command in execution
//   done       out  1       one-cycle completion pulse

module usr_seq_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef USR_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] po_fb,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] pi,
    output logic             si,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROT  = 2'b11
    } op_e;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_e           state_q, state_d;
    op_e              op_q;
    logic             fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pi_q;

    logic             accept;
    logic             abort_req;
    logic             last_step;
    logic [IDX_W-1:0] rot_idx;

    assign accept = cmd_valid && (state_q == ST_IDLE);

`ifdef USR_SEQ_ABORT_EN
    assign abort_req = abort && (state_q == ST_EXEC);
`else
    assign abort_req = 1'b0;
`endif

    // A LOAD occupies exactly one EXEC cycle; shifts/rotates leave EXEC on
    // the edge where the remaining-step counter reads 1.
    assign last_step = (op_q == OP_LOAD) || (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sel       = SEL_HOLD;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // A zero-count shift/rotate skips EXEC entirely.
                    if ((op_e'(cmd_op) != OP_LOAD) && (cmd_cnt == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                unique case (op_q)
                    OP_LOAD: sel = SEL_LOAD;
                    OP_SHL:  sel = SEL_LEFT;
                    OP_SHR:  sel = SEL_RIGHT;
                    OP_ROT:  sel = fill_q ? SEL_RIGHT : SEL_LEFT;
                    default: sel = SEL_HOLD;
                endcase
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command registers. pi keeps the last LOAD value until the next LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_LOAD;
            fill_q <= 1'b0;
            cnt_q  <= '0;
            pi_q   <= '0;
        end else if (accept) begin
            op_q   <= op_e'(cmd_op);
            fill_q <= cmd_fill;
            cnt_q  <= cmd_cnt;
            if (op_e'(cmd_op) == OP_LOAD) begin
                pi_q <= cmd_data;
            end
        end else if (state_q == ST_EXEC) begin
            if (abort_req) begin
                cnt_q <= '0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign pi = pi_q;

    // Rotation closes the loop through the register output: the bit that
    // falls off one end is fed back as the serial input at the other.
    assign rot_idx = fill_q ? IDX_W'(0) : IDX_W'(WIDTH - 1);

    always_comb begin
        si = 1'b0;
        if (state_q == ST_EXEC) begin
            unique case (op_q)
                OP_SHL, OP_SHR: si = fill_q;
                OP_ROT:         si = po_fb[rot_idx];
                default:        si = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
module tb_usr_seq_ctrl;

    logic       clk;
    logic       rst;
`ifdef USR_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       cmd_fill;
    logic [4:0] po;
    logic [1:0] sel;
    logic [4:0] pi;
    logic       si;
    logic       busy;
    logic       done;

    int checks = 0;
    int fails  = 0;

    usr_seq_ctrl #(.WIDTH(5), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef USR_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .cmd_fill  (cmd_fill),
        .po_fb     (po),
        .sel       (sel),
        .pi        (pi),
        .si        (si),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 5-bit universal shift register being sequenced.
    always @(posedge clk) begin
        if (rst) begin
            po <= 5'b0;
        end else begin
            case (sel)
                2'b01:   po <= {po[3:0], si};
                2'b10:   po <= {si, po[4:1]};
                2'b11:   po <= pi;
                default: po <= po;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] data,
                                 input logic [2:0] cnt, input logic fill);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
    endtask

    // Present a command, let it be accepted at the next edge, then drop valid.
    task automatic issue(input logic [1:0] op, input logic [4:0] data,
                         input logic [2:0] cnt, input logic fill);
        applyStimulus(op, data, cnt, fill);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 5'b0;
        cmd_cnt   = 3'b0;
        cmd_fill  = 1'b0;
`ifdef USR_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_sel",   8'(sel),       8'h0);
        checkOutput("rst_pi",    8'(pi),        8'h0);
        checkOutput("rst_si",    8'(si),        8'h0);
        checkOutput("rst_busy",  8'(busy),      8'h0);
        checkOutput("rst_done",  8'(done),      8'h0);
        checkOutput("rst_ready", 8'(cmd_ready), 8'h1);

        // LOAD 10110
        issue(2'b00, 5'b10110, 3'd5, 1'b0);
        checkOutput("ld_sel",   8'(sel),       8'h3);
        checkOutput("ld_pi",    8'(pi),        8'h16);
        checkOutput("ld_busy",  8'(busy),      8'h1);
        checkOutput("ld_ready", 8'(cmd_ready), 8'h0);
        tick();
        checkOutput("ld_done",  8'(done),      8'h1);
        checkOutput("ld_dsel",  8'(sel),       8'h0);
        checkOutput("ld_po",    8'(po),        8'h16);
        tick();
        checkOutput("ld_done0", 8'(done),      8'h0);
        checkOutput("ld_idle",  8'(cmd_ready), 8'h1);
        tick();
        checkOutput("ld_hold",  8'(po),        8'h16);

        // SHL by 2 with fill 1: 10110 -> 01101 -> 11011
        issue(2'b01, 5'b00000, 3'd2, 1'b1);
        checkOutput("shl_sel1", 8'(sel),  8'h1);
        checkOutput("shl_si1",  8'(si),   8'h1);
        checkOutput("shl_busy", 8'(busy), 8'h1);
        tick();
        checkOutput("shl_sel2", 8'(sel),  8'h1);
        checkOutput("shl_nd",   8'(done), 8'h0);
        tick();
        checkOutput("shl_done", 8'(done), 8'h1);
        checkOutput("shl_dsel", 8'(sel),  8'h0);
        checkOutput("shl_po",   8'(po),   8'h1B);
        tick();

        // LOAD 10011, ROT right by 3 -> 01110
        issue(2'b00, 5'b10011, 3'd0, 1'b0);
        tick();
        tick();
        issue(2'b11, 5'b00000, 3'd3, 1'b1);
        checkOutput("rotr_sel", 8'(sel), 8'h2);
        checkOutput("rotr_si",  8'(si),  8'h1);
        tick();
        tick();
        tick();
        checkOutput("rotr_done", 8'(done), 8'h1);
        checkOutput("rotr_po",   8'(po),   8'h0E);
        tick();

        // ROT left by 5 returns the same word
        issue(2'b11, 5'b00000, 3'd5, 1'b0);
        checkOutput("rotl_sel", 8'(sel), 8'h1);
        checkOutput("rotl_si",  8'(si),  8'h0);
        tick();
        checkOutput("rotl_si2", 8'(si),  8'h1);
        tick();
        tick();
        tick();
        tick();
        checkOutput("rotl_done", 8'(done), 8'h1);
        checkOutput("rotl_po",   8'(po),   8'h0E);
        tick();

        // SHR with cnt=0 goes straight to DONE
        issue(2'b10, 5'b00000, 3'd0, 1'b1);
        checkOutput("c0_done", 8'(done), 8'h1);
        checkOutput("c0_sel",  8'(sel),  8'h0);
        checkOutput("c0_busy", 8'(busy), 8'h0);
        checkOutput("c0_si",   8'(si),   8'h0);
        tick();
        checkOutput("c0_ready", 8'(cmd_ready), 8'h1);
        checkOutput("c0_po",    8'(po),        8'h0E);

        // Back-pressure: SHL by 1 fill 0, then a LOAD held valid throughout
        applyStimulus(2'b01, 5'b00000, 3'd1, 1'b0);
        tick();
        applyStimulus(2'b00, 5'b11111, 3'd0, 1'b0);
        checkOutput("bp_busy",  8'(busy),      8'h1);
        checkOutput("bp_rdy1",  8'(cmd_ready), 8'h0);
        tick();
        checkOutput("bp_done",  8'(done),      8'h1);
        checkOutput("bp_rdy2",  8'(cmd_ready), 8'h0);
        checkOutput("bp_po",    8'(po),        8'h1C);
        tick();
        checkOutput("bp_rdy3",  8'(cmd_ready), 8'h1);
        checkOutput("bp_isel",  8'(sel),       8'h0);
        tick();
        cmd_valid = 1'b0;
        checkOutput("bp_lsel",  8'(sel),       8'h3);
        checkOutput("bp_lpi",   8'(pi),        8'h1F);
        tick();
        checkOutput("bp_ldone", 8'(done),      8'h1);
        checkOutput("bp_lpo",   8'(po),        8'h1F);
        tick();

        // Mid-command reset drops the command without a done pulse
        issue(2'b10, 5'b00000, 3'd7, 1'b0);
        checkOutput("mr_sel", 8'(sel), 8'h2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_busy",  8'(busy),      8'h0);
        checkOutput("mr_done",  8'(done),      8'h0);
        checkOutput("mr_ready", 8'(cmd_ready), 8'h1);
        checkOutput("mr_sel0",  8'(sel),       8'h0);
        checkOutput("mr_pi",    8'(pi),        8'h0);
        checkOutput("mr_po",    8'(po),        8'h0);
        tick();
        checkOutput("mr_done2", 8'(done),      8'h0);

`ifdef USR_SEQ_ABORT_EN
        // Abort after two SHR steps on 11111 leaves 00111
        issue(2'b00, 5'b11111, 3'd0, 1'b0);
        tick();
        tick();
        issue(2'b10, 5'b00000, 3'd7, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("ab_po",    8'(po),        8'h07);
        checkOutput("ab_done",  8'(done),      8'h0);
        checkOutput("ab_ready", 8'(cmd_ready), 8'h1);
        checkOutput("ab_busy",  8'(busy),      8'h0);
        tick();
        checkOutput("ab_done2", 8'(done),      8'h0);
        checkOutput("ab_hold",  8'(po),        8'h07);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
